// File: rtl/seg_pkg.sv
// Shared constants, FSM state encoding and leading-zero helper for the
// multiplexed seven-segment scanner.
package seg_pkg;

  localparam int unsigned NDIG  = 4;
  localparam int unsigned IDX_W = $clog2(NDIG);

  localparam logic [6:0]      SEG_BLANK = 7'b1111111;
  localparam logic [NDIG-1:0] AN_OFF    = 4'b1111;

  typedef enum logic {
    S_ON   = 1'b0,
    S_DEAD = 1'b1
  } seg_state_e;

  // Bit k set when digit k and every digit above it are zero; digit 0 never qualifies.
  function automatic logic [NDIG-1:0] lz_mask(input logic [4*NDIG-1:0] val);
    logic [NDIG-1:0] m;
    logic            zero_above;
    m          = '0;
    zero_above = 1'b1;
    for (int k = NDIG - 1; k >= 1; k--) begin
      zero_above = zero_above & (val[4*k +: 4] == 4'd0);
      m[k]       = zero_above;
    end
    return m;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_bcd.sv
// BCD to active-low seven-segment decoder; seg bit order is {g,f,e,d,c,b,a}.
module seg_scan_ctrl_bcd
  import seg_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0:    o_seg = 7'b1000000;
      4'd1:    o_seg = 7'b1111001;
      4'd2:    o_seg = 7'b0100100;
      4'd3:    o_seg = 7'b0110000;
      4'd4:    o_seg = 7'b0011001;
      4'd5:    o_seg = 7'b0010010;
      4'd6:    o_seg = 7'b0000010;
      4'd7:    o_seg = 7'b1111000;
      4'd8:    o_seg = 7'b0000000;
      4'd9:    o_seg = 7'b0010000;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with dead-time ghosting guard,
// leading-zero blanking and frame-aligned display updates.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned DEAD_CYC    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        upd_done
);

  localparam int unsigned CNT_MAX = (REFRESH_DIV > DEAD_CYC) ? REFRESH_DIV : DEAD_CYC;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NDIG - 1);

  if (REFRESH_DIV < 2) begin : g_bad_refresh
    $error("REFRESH_DIV must be at least 2");
  end
  if (DEAD_CYC < 1) begin : g_bad_dead
    $error("DEAD_CYC must be at least 1");
  end

  seg_state_e        r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [CNT_W-1:0]  r_cnt;
  logic [15:0]       r_disp_val;
  logic [NDIG-1:0]   r_disp_dp;
  logic [15:0]       r_pend_val;
  logic [NDIG-1:0]   r_pend_dp;
  logic              r_pend;
  logic [NDIG-1:0]   r_an;
  logic [6:0]        r_seg;
  logic              r_dp;
  logic              r_upd_done;

  logic [3:0]        w_nib;
  logic [6:0]        w_dec;
  logic [NDIG-1:0]   w_lz;
  logic              w_blank;
  logic              w_on_done;
  logic              w_dead_done;
  logic              w_commit;
  logic [15:0]       w_commit_val;
  logic [NDIG-1:0]   w_commit_dp;
  logic [NDIG-1:0]   w_an_on;

  seg_scan_ctrl_bcd u_bcd (
    .i_bcd (w_nib),
    .o_seg (w_dec)
  );

  assign w_nib   = r_disp_val[{r_idx, 2'b00} +: 4];
  assign w_lz    = lz_mask(r_disp_val) & {NDIG{blank_lz}};
  // Out-of-range nibbles never reach the pins, whatever the decoder makes of them.
  assign w_blank = w_lz[r_idx] | (w_nib > 4'd9);
  assign w_an_on = ~(NDIG'(1) << r_idx);

  assign w_on_done   = (r_state == S_ON)   && (r_cnt == ON_LAST);
  assign w_dead_done = (r_state == S_DEAD) && (r_cnt == DEAD_LAST);

  // A load landing on the frame boundary itself is committed directly.
  assign w_commit     = w_dead_done && (r_idx == IDX_LAST) && (r_pend || load);
  assign w_commit_val = load ? value : r_pend_val;
  assign w_commit_dp  = load ? dp_in : r_pend_dp;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_DEAD;
      r_idx      <= IDX_LAST;
      r_cnt      <= '0;
      r_disp_val <= '0;
      r_disp_dp  <= '0;
      r_pend_val <= '0;
      r_pend_dp  <= '0;
      r_pend     <= 1'b0;
      r_an       <= AN_OFF;
      r_seg      <= SEG_BLANK;
      r_dp       <= 1'b1;
      r_upd_done <= 1'b0;
    end else begin
      r_upd_done <= 1'b0;

      if (r_state == S_ON) begin
        r_an  <= w_an_on;
        r_seg <= w_blank ? SEG_BLANK : w_dec;
        r_dp  <= ~r_disp_dp[r_idx];
      end else begin
        r_an  <= AN_OFF;
        r_seg <= SEG_BLANK;
        r_dp  <= 1'b1;
      end

      if (load) begin
        r_pend_val <= value;
        r_pend_dp  <= dp_in;
        r_pend     <= 1'b1;
      end

      unique case (r_state)
        S_ON: begin
          if (w_on_done) begin
            r_state <= S_DEAD;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DEAD: begin
          if (w_dead_done) begin
            r_state <= S_ON;
            r_cnt   <= '0;
            r_idx   <= r_idx + IDX_W'(1);
            if (w_commit) begin
              r_disp_val <= w_commit_val;
              r_disp_dp  <= w_commit_dp;
              r_pend     <= 1'b0;
              r_upd_done <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_DEAD;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign an       = r_an;
  assign seg      = r_seg;
  assign dp       = r_dp;
  assign upd_done = r_upd_done;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: expected digit patterns are queued per frame
// and popped as each digit lights; lit/dead run lengths and update pulses are tracked.
module tb_seg_scan_ctrl;
  import seg_pkg::*;

  localparam int unsigned RDIV = 4;
  localparam int unsigned DCYC = 1;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        load     = 1'b0;
  logic [15:0] value    = '0;
  logic [3:0]  dp_in    = '0;
  logic        blank_lz = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        upd_done;

  exp_t q[$];
  int   n_vec   = 0;
  int   n_err   = 0;
  int   upd_cnt = 0;
  logic mon_en  = 1'b0;

  seg_scan_ctrl #(
    .REFRESH_DIV (RDIV),
    .DEAD_CYC    (DCYC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .value    (value),
    .dp_in    (dp_in),
    .blank_lz (blank_lz),
    .an       (an),
    .seg      (seg),
    .dp       (dp),
    .upd_done (upd_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'd0:    glyph = 7'b1000000;
      4'd1:    glyph = 7'b1111001;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1111000;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0010000;
      default: glyph = SEG_BLANK;
    endcase
  endfunction

  function automatic void push_frame(input logic [15:0] val, input logic [3:0] dps,
                                     input logic blz);
    exp_t       e;
    logic [3:0] nib;
    logic       blank;
    for (int k = 0; k < 4; k++) begin
      nib      = val[4*k +: 4];
      blank    = (nib > 4'd9) || (blz && (k > 0) && ((val >> (4 * k)) == 16'd0));
      e.an     = 4'b1111;
      e.an[k]  = 1'b0;
      e.seg    = blank ? SEG_BLANK : glyph(nib);
      e.dp     = ~dps[k];
      q.push_back(e);
    end
  endfunction

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    logic lit;
    logic prev_lit;
    logic seen_lit;
    int   run_len;
    exp_t e;
    prev_lit = 1'b0;
    seen_lit = 1'b0;
    run_len  = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!mon_en) begin
        prev_lit = 1'b0;
        seen_lit = 1'b0;
        run_len  = 0;
      end else begin
        lit = (an !== AN_OFF);
        if (upd_done === 1'b1) begin
          upd_cnt++;
          n_vec++;
          if (an !== AN_OFF) begin
            n_err++;
            $display("FAIL upd_in_gap: an=%b when upd_done high, exp %b", an, AN_OFF);
          end
        end
        if (!lit) begin
          n_vec++;
          if (seg !== SEG_BLANK || dp !== 1'b1) begin
            n_err++;
            $display("FAIL dead_pins: seg=%b dp=%b exp seg=%b dp=1", seg, dp, SEG_BLANK);
          end
        end
        if (lit && !prev_lit) begin
          if (seen_lit) begin
            n_vec++;
            if (run_len != DCYC) begin
              n_err++;
              $display("FAIL gap_len: got %0d cycles exp %0d", run_len, DCYC);
            end
          end
          if (q.size() > 0) begin
            e = q.pop_front();
            n_vec++;
            if ({an, seg, dp} !== e) begin
              n_err++;
              $display("FAIL digit: got an=%b seg=%b dp=%b exp an=%b seg=%b dp=%b",
                       an, seg, dp, e.an, e.seg, e.dp);
            end
          end
          run_len  = 1;
          seen_lit = 1'b1;
        end else if (!lit && prev_lit) begin
          n_vec++;
          if (run_len != RDIV) begin
            n_err++;
            $display("FAIL lit_len: got %0d cycles exp %0d", run_len, RDIV);
          end
          run_len = 1;
        end else begin
          run_len++;
        end
        prev_lit = lit;
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    wait_cyc(2);
    rst_n   = 1'b1;
    upd_cnt = 0;
    q.delete();
    mon_en  = 1'b1;
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    load  = 1'b1;
    value = v;
    dp_in = d;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Waits for the queue to empty, then lets the last digit's lit run finish.
  task automatic wait_drain(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) wait_cyc(4);
  endtask

  task automatic test_reset();
    mon_en = 1'b0;
    rst_n  = 1'b0;
    wait_cyc(3);
    n_vec++;
    if (an !== AN_OFF) begin
      n_err++; $display("FAIL reset_an: got %b exp %b", an, AN_OFF);
    end
    n_vec++;
    if (seg !== SEG_BLANK) begin
      n_err++; $display("FAIL reset_seg: got %b exp %b", seg, SEG_BLANK);
    end
    n_vec++;
    if (dp !== 1'b1) begin
      n_err++; $display("FAIL reset_dp: got %b exp 1", dp);
    end
    n_vec++;
    if (upd_done !== 1'b0) begin
      n_err++; $display("FAIL reset_upd: got %b exp 0", upd_done);
    end
  endtask

  task automatic test_scan_zero();
    logic ok;
    blank_lz = 1'b0;
    do_reset();
    push_frame(16'h0000, 4'b0000, 1'b0);
    wait_cyc(3);
    do_load(16'h0000, 4'b0000);
    push_frame(16'h0000, 4'b0000, 1'b0);
    wait_drain(ok);
    n_vec++;
    if (!ok) begin
      n_err++; $display("FAIL scan_zero_drain: %0d digits never shown, exp 0", q.size());
    end
    n_vec++;
    if (upd_cnt != 1) begin
      n_err++; $display("FAIL scan_zero_upd: got %0d pulses exp 1", upd_cnt);
    end
  endtask

  task automatic test_mid_frame_load();
    logic ok;
    do_reset();
    push_frame(16'h0000, 4'b0000, 1'b0);
    wait_cyc(5);
    do_load(16'h1234, 4'b0000);
    push_frame(16'h1234, 4'b0000, 1'b0);
    wait_drain(ok);
    n_vec++;
    if (!ok) begin
      n_err++; $display("FAIL mid_load_drain: %0d digits never shown, exp 0", q.size());
    end
    n_vec++;
    if (upd_cnt != 1) begin
      n_err++; $display("FAIL mid_load_upd: got %0d pulses exp 1", upd_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic ok;
    do_reset();
    push_frame(16'h0000, 4'b0000, 1'b0);
    wait_cyc(2);
    do_load(16'h1111, 4'b1111);
    wait_cyc(3);
    do_load(16'h0042, 4'b0001);
    push_frame(16'h0042, 4'b0001, 1'b0);
    wait_drain(ok);
    n_vec++;
    if (!ok) begin
      n_err++; $display("FAIL b2b_drain: %0d digits never shown, exp 0", q.size());
    end
    n_vec++;
    if (upd_cnt != 1) begin
      n_err++; $display("FAIL b2b_upd: got %0d pulses exp 1", upd_cnt);
    end
  endtask

  task automatic test_blank_lz();
    logic ok;
    blank_lz = 1'b1;
    do_reset();
    push_frame(16'h0000, 4'b0000, 1'b1);
    wait_cyc(3);
    do_load(16'h0042, 4'b0000);
    push_frame(16'h0042, 4'b0000, 1'b1);
    wait_cyc(20);
    do_load(16'h0000, 4'b0100);
    push_frame(16'h0000, 4'b0100, 1'b1);
    wait_drain(ok);
    n_vec++;
    if (!ok) begin
      n_err++; $display("FAIL blank_lz_drain: %0d digits never shown, exp 0", q.size());
    end
    n_vec++;
    if (upd_cnt != 2) begin
      n_err++; $display("FAIL blank_lz_upd: got %0d pulses exp 2", upd_cnt);
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_dp_hex();
    logic ok;
    do_reset();
    push_frame(16'h0000, 4'b0000, 1'b0);
    wait_cyc(3);
    do_load(16'h00A5, 4'b0010);
    push_frame(16'h00A5, 4'b0010, 1'b0);
    wait_drain(ok);
    n_vec++;
    if (!ok) begin
      n_err++; $display("FAIL dp_hex_drain: %0d digits never shown, exp 0", q.size());
    end
    n_vec++;
    if (upd_cnt != 1) begin
      n_err++; $display("FAIL dp_hex_upd: got %0d pulses exp 1", upd_cnt);
    end
  endtask

  task automatic test_load_at_commit();
    logic ok;
    load  = 1'b1;
    value = 16'h9876;
    dp_in = 4'b1000;
    do_reset();
    push_frame(16'h9876, 4'b1000, 1'b0);
    @(negedge clk);
    load = 1'b0;
    push_frame(16'h9876, 4'b1000, 1'b0);
    wait_drain(ok);
    n_vec++;
    if (!ok) begin
      n_err++; $display("FAIL at_commit_drain: %0d digits never shown, exp 0", q.size());
    end
    n_vec++;
    if (upd_cnt != 1) begin
      n_err++; $display("FAIL at_commit_upd: got %0d pulses exp 1", upd_cnt);
    end
  endtask

  task automatic test_reset_pending();
    logic ok;
    do_reset();
    push_frame(16'h0000, 4'b0000, 1'b0);
    wait_cyc(3);
    do_load(16'h5678, 4'b0101);
    wait_cyc(6);
    n_vec++;
    if (an === AN_OFF) begin
      n_err++; $display("FAIL pre_reset_lit: an=%b exp a lit digit", an);
    end
    mon_en = 1'b0;
    q.delete();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_vec++;
    if (an !== AN_OFF) begin
      n_err++; $display("FAIL midreset_an: got %b exp %b", an, AN_OFF);
    end
    n_vec++;
    if (seg !== SEG_BLANK) begin
      n_err++; $display("FAIL midreset_seg: got %b exp %b", seg, SEG_BLANK);
    end
    n_vec++;
    if (dp !== 1'b1) begin
      n_err++; $display("FAIL midreset_dp: got %b exp 1", dp);
    end
    n_vec++;
    if (upd_done !== 1'b0) begin
      n_err++; $display("FAIL midreset_upd: got %b exp 0", upd_done);
    end
    @(negedge clk);
    rst_n   = 1'b1;
    upd_cnt = 0;
    mon_en  = 1'b1;
    push_frame(16'h0000, 4'b0000, 1'b0);
    push_frame(16'h0000, 4'b0000, 1'b0);
    wait_drain(ok);
    n_vec++;
    if (!ok) begin
      n_err++; $display("FAIL discard_drain: %0d digits never shown, exp 0", q.size());
    end
    n_vec++;
    if (upd_cnt != 0) begin
      n_err++; $display("FAIL discard_upd: got %0d pulses exp 0", upd_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_scan_zero();
    test_mid_frame_load();
    test_back_to_back();
    test_blank_lz();
    test_dp_hex();
    test_load_at_commit();
    test_reset_pending();
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
